fetch_ctrl: RTL and testbench

Fetch-stage controller that sequences the PC register and the instruction-memory port. Decides each cycle whether the PC holds, advances by 4 or jumps to a redirect/trap target. Runs a single-outstanding request/response handshake with instruction memory and holds the fetched instruction in a one-entry slot feeding the IF/ID register. It discards responses made stale by a redirect.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and imem (slave).
// Single-outstanding req/gnt request phase, rvalid/rdata response phase.
interface fetch_ctrl_if #(
    parameter int unsigned width = 32
);
    logic             imem_req_o;
    logic [width-1:0] imem_addr_o;
    logic             imem_gnt_i;
    logic             imem_rvalid_i;
    logic [31:0]      imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: PC sequencing, single-outstanding imem handshake, one-entry IF slot.
// Optional FETCH_MISALIGN_CHK_EN rejects redirects whose target has bits [1:0] != 0.
module fetch_ctrl #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [width-1:0] pc_i,
    output logic [width-1:0] pc_next_o,
    output logic             pc_hold_o,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [width-1:0] redirect_pc_i,
    input  logic             trap_i,
    input  logic [width-1:0] trap_vec_i,
    fetch_ctrl_if.master     imem,
    output logic             if_valid_o,
    output logic [width-1:0] if_pc_o,
    output logic [31:0]      if_instr_o,
    output logic             fetch_misalign_o
);
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              kill_q, kill_d;
    logic [width-1:0]  req_pc_q, req_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [width-1:0]  if_pc_q, if_pc_d;
    logic [ILEN-1:0]   if_instr_q, if_instr_d;

    logic              free;
    logic              flush;
    logic              redir_bad;
    logic              req_c;
    logic              grant;
    logic [width-1:0]  pc_plus4;
    logic [width-1:0]  trap_tgt;
    logic [width-1:0]  redir_tgt;

    assign free      = !if_valid_q || !stall_i;
    assign flush     = trap_i || redirect_i;
    assign pc_plus4  = pc_i + width'(4);
    assign trap_tgt  = trap_vec_i & ~width'(3);
    assign redir_tgt = redirect_pc_i & ~width'(3);

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    // Trap wins over redirect, so only an un-trapped misaligned redirect is rejected.
    assign redir_bad        = redirect_i && !trap_i && (redirect_pc_i[1:0] != 2'b00);
    assign misalign_d       = redir_bad;
    assign fetch_misalign_o = misalign_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) misalign_q <= 1'b0;
        else       misalign_q <= misalign_d;
    end
`else
    assign redir_bad        = 1'b0;
    assign fetch_misalign_o = 1'b0;
`endif

    // Next-state, slot update and request generation.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        req_pc_d   = req_pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        req_c      = 1'b0;

        if (if_valid_q && !stall_i) if_valid_d = 1'b0;
        if (flush)                  if_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                req_c = free && !flush;
                if (req_c && imem.imem_gnt_i) begin
                    req_pc_d = pc_i;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid_i) begin
                    state_d = ST_REQ;
                    if (!kill_q && !flush) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = imem.imem_rdata_i;
                    end else begin
                        kill_d = 1'b0;
                    end
                end else if (flush) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant = req_c && imem.imem_gnt_i;

    // PC register control: load target on flush, pc+4 on grant, otherwise hold.
    always_comb begin
        pc_next_o = pc_plus4;
        pc_hold_o = 1'b1;
        if (flush && !redir_bad) begin
            pc_next_o = trap_i ? trap_tgt : redir_tgt;
            pc_hold_o = 1'b0;
        end else if (grant) begin
            pc_hold_o = 1'b0;
        end
        if (rst_i) pc_hold_o = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            kill_q     <= 1'b0;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem.imem_req_o  = req_c;
    assign imem.imem_addr_o = pc_i;
    assign if_valid_o       = if_valid_q;
    assign if_pc_o          = if_pc_q;
    assign if_instr_o       = if_instr_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model, a latency-programmable imem model
// and a scoreboard monitor that checks every grant address and every consumed slot.
module tb_fetch_ctrl;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } slot_t;

    logic          clk;
    logic          rst;
    logic [W-1:0]  pc_q;
    logic [W-1:0]  pc_next;
    logic          pc_hold;
    logic          stall;
    logic          redirect;
    logic [W-1:0]  redirect_pc;
    logic          trap;
    logic [W-1:0]  trap_vec;
    logic          if_valid;
    logic [W-1:0]  if_pc;
    logic [31:0]   if_instr;
    logic          misalign;

    logic          mem_gnt_en;
    int            mem_lat;

    slot_t         exp_slot_q[$];
    logic [31:0]   exp_addr_q[$];
    int            checks = 0;
    int            failures = 0;

    fetch_ctrl_if #(.width(W)) bus ();

    fetch_ctrl #(.width(W)) dut (
        .clk             (clk),
        .rst_i           (rst),
        .pc_i            (pc_q),
        .pc_next_o       (pc_next),
        .pc_hold_o       (pc_hold),
        .stall_i         (stall),
        .redirect_i      (redirect),
        .redirect_pc_i   (redirect_pc),
        .trap_i          (trap),
        .trap_vec_i      (trap_vec),
        .imem            (bus),
        .if_valid_o      (if_valid),
        .if_pc_o         (if_pc),
        .if_instr_o      (if_instr),
        .fetch_misalign_o(misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register driven by the controller's hold/next outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           pc_q <= 32'h8000_0000;
        else if (!pc_hold) pc_q <= pc_next;
    end

    assign bus.imem_gnt_i = mem_gnt_en;

    // Instruction memory: response mem_lat cycles after the grant, data = {addr[15:0], 16'h0013}.
    initial begin
        logic        pend;
        logic        fire;
        int          cnt;
        logic [31:0] paddr;
        pend  = 1'b0;
        cnt   = 0;
        paddr = '0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            fire = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (bus.imem_req_o && bus.imem_gnt_i) begin
                    pend  = 1'b1;
                    cnt   = mem_lat;
                    paddr = bus.imem_addr_o;
                end
                if (pend) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        fire = 1'b1;
                        pend = 1'b0;
                    end
                end
            end
            #1;
            bus.imem_rvalid_i = fire;
            bus.imem_rdata_i  = fire ? {paddr[15:0], 16'h0013} : 32'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: grants and slot consumes are checked against queued expectations.
    initial begin
        slot_t s;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.imem_req_o && bus.imem_gnt_i) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant: got addr %h expected none", bus.imem_addr_o);
                    end else begin
                        chk("grant_addr", bus.imem_addr_o, exp_addr_q.pop_front());
                    end
                end
                if (if_valid && !stall) begin
                    if (exp_slot_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_slot: got pc %h instr %h expected none", if_pc, if_instr);
                    end else begin
                        s = exp_slot_q.pop_front();
                        chk("slot_pc", if_pc, s.pc);
                        chk("slot_instr", if_instr, s.instr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; trap = 1'b0;
        redirect_pc = '0; trap_vec = '0; mem_gnt_en = 1'b1; mem_lat = 1;
        tick(); tick();
        #2;
        chk("rst_valid", 32'(if_valid), 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_instr", if_instr, 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_req", 32'(bus.imem_req_o), 0);
        chk("rst_hold", 32'(pc_hold), 1);
        exp_addr_q.push_back(32'h8000_0000);
        exp_slot_q.push_back('{pc: 32'h8000_0000, instr: 32'h0000_0013});

        tick(); rst = 1'b0;                                    // c0: IDLE
        #2; chk("c0_req", 32'(bus.imem_req_o), 0); chk("c0_hold", 32'(pc_hold), 1);
        tick();                                                // c1: first request, granted
        #2; chk("c1_req", 32'(bus.imem_req_o), 1); chk("c1_addr", bus.imem_addr_o, 32'h8000_0000);
        chk("c1_hold", 32'(pc_hold), 0); chk("c1_next", pc_next, 32'h8000_0004);
        exp_addr_q.push_back(32'h8000_0004);
        exp_slot_q.push_back('{pc: 32'h8000_0004, instr: 32'h0004_0013});
        tick();                                                // c2: WAIT
        #2; chk("c2_req", 32'(bus.imem_req_o), 0); chk("c2_hold", 32'(pc_hold), 1);
        chk("c2_pc", pc_q, 32'h8000_0004);
        tick();                                                // c3: slot I0, next request
        #2; chk("c3_valid", 32'(if_valid), 1); chk("c3_req", 32'(bus.imem_req_o), 1);
        tick();                                                // c4: WAIT
        tick(); stall = 1'b1;                                  // c5..c7: slot held under stall
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_req", 32'(bus.imem_req_o), 0); chk("stall_hold", 32'(pc_hold), 1);
            chk("stall_valid", 32'(if_valid), 1); chk("stall_pc", if_pc, 32'h8000_0004);
            chk("stall_instr", if_instr, 32'h0004_0013);
            if (i < 2) tick();
        end
        exp_addr_q.push_back(32'h8000_0008);
        tick(); stall = 1'b0; mem_lat = 3;                     // c8: consume + request resumes
        #2; chk("c8_req", 32'(bus.imem_req_o), 1);
        tick(); redirect = 1'b1; redirect_pc = 32'h8000_0100;  // c9: redirect during WAIT
        #2; chk("c9_hold", 32'(pc_hold), 0); chk("c9_next", pc_next, 32'h8000_0100);
        chk("c9_req", 32'(bus.imem_req_o), 0);
        tick(); redirect = 1'b0;                               // c10
        #2; chk("c10_pc", pc_q, 32'h8000_0100); chk("c10_req", 32'(bus.imem_req_o), 0);
        tick(); mem_lat = 1;                                   // c11: stale response arrives
        #2; chk("c11_valid", 32'(if_valid), 0);
        exp_addr_q.push_back(32'h8000_0100);
        tick();                                                // c12: new request at target
        #2; chk("c12_valid", 32'(if_valid), 0); chk("c12_req", 32'(bus.imem_req_o), 1);
        tick();                                                // c13
        tick(); stall = 1'b1; trap = 1'b1; trap_vec = 32'h8000_0040;
        redirect = 1'b1; redirect_pc = 32'h8000_0100;          // c14: trap + redirect together
        #2; chk("c14_valid", 32'(if_valid), 1); chk("c14_pc", if_pc, 32'h8000_0100);
        chk("c14_instr", if_instr, 32'h0100_0013); chk("c14_hold", 32'(pc_hold), 0);
        chk("c14_next", pc_next, 32'h8000_0040); chk("c14_req", 32'(bus.imem_req_o), 0);
        exp_addr_q.push_back(32'h8000_0040);
        tick(); stall = 1'b0; trap = 1'b0; redirect = 1'b0;    // c15
        #2; chk("c15_valid", 32'(if_valid), 0); chk("c15_pc", pc_q, 32'h8000_0040);
        tick(); redirect = 1'b1; redirect_pc = 32'h8000_0102;  // c16: misaligned redirect with rvalid
`ifdef FETCH_MISALIGN_CHK_EN
        tgt = 32'h8000_0044;
        #2; chk("c16_hold", 32'(pc_hold), 1); chk("c16_next", pc_next, 32'h8000_0048);
`else
        tgt = 32'h8000_0100;
        #2; chk("c16_hold", 32'(pc_hold), 0); chk("c16_next", pc_next, 32'h8000_0100);
`endif
        exp_addr_q.push_back(tgt);
        exp_slot_q.push_back('{pc: tgt, instr: {tgt[15:0], 16'h0013}});
        tick(); redirect = 1'b0;                               // c17
        #2; chk("c17_valid", 32'(if_valid), 0); chk("c17_pc", pc_q, tgt);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("c17_misalign", 32'(misalign), 1);
`else
        chk("c17_misalign", 32'(misalign), 0);
`endif
        exp_addr_q.push_back(tgt + 32'd4);
        tick();                                                // c18
        #2; chk("c18_misalign", 32'(misalign), 0);
        tick(); mem_lat = 3;                                   // c19: consume, grant tgt+4
        tick(); rst = 1'b1;                                    // c20: reset mid-WAIT
        #2; chk("mid_rst_valid", 32'(if_valid), 0); chk("mid_rst_pc", if_pc, 0);
        chk("mid_rst_instr", if_instr, 0); chk("mid_rst_misalign", 32'(misalign), 0);
        chk("mid_rst_req", 32'(bus.imem_req_o), 0); chk("mid_rst_hold", 32'(pc_hold), 1);
        chk("mid_rst_pcreg", pc_q, 32'h8000_0000);
        mem_lat = 1;
        exp_addr_q.push_back(32'h8000_0000);
        exp_slot_q.push_back('{pc: 32'h8000_0000, instr: 32'h0000_0013});
        tick(); rst = 1'b0;                                    // r0
        #2; chk("r0_req", 32'(bus.imem_req_o), 0);
        tick();                                                // r1
        #2; chk("r1_req", 32'(bus.imem_req_o), 1); chk("r1_addr", bus.imem_addr_o, 32'h8000_0000);
        tick();                                                // r2
        tick(); mem_gnt_en = 1'b0;                             // r3: ungranted request
        #2; chk("r3_valid", 32'(if_valid), 1); chk("r3_req", 32'(bus.imem_req_o), 1);
        chk("r3_hold", 32'(pc_hold), 1);
        tick(); tick();
        chk("sb_addr_left", 32'(exp_addr_q.size()), 0);
        chk("sb_slot_left", 32'(exp_slot_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
